// File: rtl/serial_word_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_queue_pkg
// Brief    : Shared types and constants for the serial_word_queue slice.
//            - state_t  : loader FSM states (IDLE, LOAD, HOLD)
//            - ERR_OVF / ERR_UNF : bit positions inside err_out
//            - cnt_w()  : width of an occupancy counter able to hold 0..depth
// Revision : 1.0  initial release
// ============================================================================
package serial_word_queue_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;

    // Occupancy runs 0..depth inclusive, so one more code than a pointer.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_word_queue_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Brief    : Conditions one slow, asynchronous control level into a single
//            clock rising-edge pulse.
//            2-flop synchroniser -> optional debounce filter -> edge detect.
//            Input rise to o_pulse high: 3 clocks (3+DEBOUNCE_CYC with filter).
// Macro    : SERIAL_WORD_QUEUE_DEBOUNCE_EN enables the debounce filter and
//            the DEBOUNCE_CYC parameter.
// Ports    : clk      in  system clock
//            rst      in  asynchronous active-high reset
//            i_level  in  raw asynchronous level
//            o_pulse  out one-cycle pulse on a filtered rising edge
// Revision : 1.0  initial release
// ============================================================================
module sync_edge_det
    import serial_word_queue_pkg::*;
`ifdef SERIAL_WORD_QUEUE_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYC = 4
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_pulse
);

    logic [1:0] r_sync;
    logic       r_prev;
    logic       w_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_level};
        end
    end

`ifdef SERIAL_WORD_QUEUE_DEBOUNCE_EN
    localparam int unsigned c_deb_w = $clog2(DEBOUNCE_CYC + 1);

    logic [c_deb_w-1:0] r_deb_cnt;
    logic               r_filt;

    // The filtered level follows the synchronised level only after the new
    // value has been seen on DEBOUNCE_CYC consecutive clocks; any return to
    // the old level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_cnt <= '0;
            r_filt    <= 1'b0;
        end else if (r_sync[1] != r_filt) begin
            if (r_deb_cnt == c_deb_w'(DEBOUNCE_CYC - 1)) begin
                r_filt    <= r_sync[1];
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end else begin
            r_deb_cnt <= '0;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev  <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            r_prev  <= w_level;
            o_pulse <= w_level & ~r_prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_word_queue.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_queue
// Brief    : Serial bit loader feeding a DEPTH-entry circular FIFO.
//            Bits strobed on write_in assemble a DATA_W-bit word; an enqueue
//            edge pushes it, a dequeue edge pops the oldest word to data_out.
//            All control inputs are slow levels, synchronised and
//            edge-detected internally.
// Macro    : SERIAL_WORD_QUEUE_DEBOUNCE_EN adds a DEBOUNCE_CYC-clock debounce
//            filter on every control input (and the DEBOUNCE_CYC parameter).
// Ports    : clock_1MHz in  system clock
//            rst        in  asynchronous active-high reset
//            data_in    in  serial data bit
//            write_in   in  bit strobe level (rising edge acts)
//            enqueue_in in  push request level (rising edge acts)
//            dequeue_in in  pop request level (rising edge acts)
//            status_out out 1 while the loader accepts bits (LOAD)
//            data_out   out last dequeued word (registered)
//            count_out  out FIFO occupancy 0..DEPTH
//            full_out   out occupancy == DEPTH
//            empty_out  out occupancy == 0
//            err_out    out sticky [0] overflow, [1] underflow
// Revision : 1.0  initial release
// ============================================================================
module serial_word_queue
    import serial_word_queue_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
`ifdef SERIAL_WORD_QUEUE_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYC = 4
`endif
)
(
    input  logic                    clock_1MHz,
    input  logic                    rst,
    input  logic                    data_in,
    input  logic                    write_in,
    input  logic                    enqueue_in,
    input  logic                    dequeue_in,
    output logic                    status_out,
    output logic [DATA_W-1:0]       data_out,
    output logic [cnt_w(DEPTH)-1:0] count_out,
    output logic                    full_out,
    output logic                    empty_out,
    output logic [1:0]              err_out
);

    localparam int unsigned c_cnt_w = cnt_w(DEPTH);
    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_idx_w = $clog2(DATA_W);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [2:0] w_ctrl_lvl;
    logic [2:0] w_ctrl_pulse;
    logic [1:0] r_data_sync;
    logic       w_wr_pulse;
    logic       w_enq_pulse;
    logic       w_deq_pulse;

    assign w_ctrl_lvl  = {dequeue_in, enqueue_in, write_in};
    assign w_wr_pulse  = w_ctrl_pulse[0];
    assign w_enq_pulse = w_ctrl_pulse[1];
    assign w_deq_pulse = w_ctrl_pulse[2];

    for (genvar g = 0; g < 3; g++) begin : g_ctrl
`ifdef SERIAL_WORD_QUEUE_DEBOUNCE_EN
        sync_edge_det #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_sed (
            .clk     (clock_1MHz),
            .rst     (rst),
            .i_level (w_ctrl_lvl[g]),
            .o_pulse (w_ctrl_pulse[g])
        );
`else
        sync_edge_det u_sed (
            .clk     (clock_1MHz),
            .rst     (rst),
            .i_level (w_ctrl_lvl[g]),
            .o_pulse (w_ctrl_pulse[g])
        );
`endif
    end

    // data_in is only consumed alongside a write pulse, so a plain
    // synchroniser is enough; its level has long settled by then.
    always_ff @(posedge clock_1MHz or posedge rst) begin
        if (rst) begin
            r_data_sync <= 2'b00;
        end else begin
            r_data_sync <= {r_data_sync[0], data_in};
        end
    end

    // ------------------------------------------------------------------
    // Loader and FIFO
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [DATA_W-1:0]    r_shift;
    logic [c_idx_w-1:0]   r_bit_cnt;
    logic [c_idx_w-1:0]   w_pos;
    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ovf;
    logic                 w_unf;

    assign w_full  = (r_count == c_cnt_w'(DEPTH));
    assign w_empty = (r_count == '0);

    assign w_pos = LSB_FIRST ? r_bit_cnt : (c_idx_w'(DATA_W - 1) - r_bit_cnt);

    // A full FIFO still accepts a push when a pop happens in the same cycle,
    // since the pop frees the slot the push lands in. An empty FIFO never
    // bypasses: the pop is refused even if a push arrives alongside it.
    assign w_push = (r_state == HOLD) && w_enq_pulse && (!w_full || w_deq_pulse);
    assign w_ovf  = (r_state == HOLD) && w_enq_pulse && w_full && !w_deq_pulse;
    assign w_pop  = w_deq_pulse && !w_empty;
    assign w_unf  = w_deq_pulse && w_empty;

    always_ff @(posedge clock_1MHz or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            status_out <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            data_out   <= '0;
            err_out    <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state    <= LOAD;
                    status_out <= 1'b1;
                end
                LOAD: begin
                    if (w_wr_pulse) begin
                        r_shift[w_pos] <= r_data_sync[1];
                        if (r_bit_cnt == c_idx_w'(DATA_W - 1)) begin
                            r_bit_cnt  <= '0;
                            r_state    <= HOLD;
                            status_out <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_push) begin
                        r_state    <= LOAD;
                        status_out <= 1'b1;
                        r_shift    <= '0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    status_out <= 1'b0;
                end
            endcase

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                data_out <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            if (w_ovf) begin
                err_out[ERR_OVF] <= 1'b1;
            end
            if (w_unf) begin
                err_out[ERR_UNF] <= 1'b1;
            end
        end
    end

    // Storage carries no reset; its contents are meaningless until written.
    always_ff @(posedge clock_1MHz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    assign count_out = r_count;
    assign full_out  = w_full;
    assign empty_out = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_serial_word_queue
// Brief    : Self-checking bench for serial_word_queue (DATA_W=8, DEPTH=8,
//            LSB_FIRST=1). Words are strobed in bit by bit with slow level
//            inputs; a queue of expected words is pushed on every accepted
//            enqueue and popped/compared on every dequeue.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_word_queue;

    logic       clock_1MHz;
    logic       rst;
    logic       data_in;
    logic       write_in;
    logic       enqueue_in;
    logic       dequeue_in;
    logic       status_out;
    logic [7:0] data_out;
    logic [3:0] count_out;
    logic       full_out;
    logic       empty_out;
    logic [1:0] err_out;

    int         n_cmp;
    int         n_fail;
    logic [7:0] sb [$];
    logic [7:0] exp_w;

    serial_word_queue dut (
        .clock_1MHz (clock_1MHz),
        .rst        (rst),
        .data_in    (data_in),
        .write_in   (write_in),
        .enqueue_in (enqueue_in),
        .dequeue_in (dequeue_in),
        .status_out (status_out),
        .data_out   (data_out),
        .count_out  (count_out),
        .full_out   (full_out),
        .empty_out  (empty_out),
        .err_out    (err_out)
    );

    initial clock_1MHz = 1'b0;
    always #500 clock_1MHz = ~clock_1MHz;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_1MHz);
            #1;
        end
    endtask

    task automatic strobe_bit(input logic b);
        data_in  = b;
        write_in = 1'b1;
        tick(10);
        write_in = 1'b0;
        tick(10);
    endtask

    task automatic load_word(input logic [7:0] w);
        for (int k = 0; k < 8; k++) begin
            strobe_bit(w[k]);
        end
    endtask

    task automatic do_enq();
        enqueue_in = 1'b1;
        tick(10);
        enqueue_in = 1'b0;
        tick(10);
    endtask

    task automatic do_deq();
        dequeue_in = 1'b1;
        tick(10);
        dequeue_in = 1'b0;
        tick(10);
    endtask

    task automatic apply_reset();
        int waited;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        waited = 0;
        while (status_out !== 1'b1 && waited < 5) begin
            tick(1);
            waited++;
        end
        n_cmp++;
        if (status_out !== 1'b1) begin
            $display("FAIL reset_release_status: status_out=%b required 1 within 5 clocks", status_out);
            n_fail++;
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_cmp++; if (status_out !== 1'b0) begin $display("FAIL rst_status: got %b exp 0", status_out); n_fail++; end
        n_cmp++; if (data_out !== 8'h00) begin $display("FAIL rst_data: got %h exp 00", data_out); n_fail++; end
        n_cmp++; if (count_out !== 4'd0) begin $display("FAIL rst_count: got %0d exp 0", count_out); n_fail++; end
        n_cmp++; if (empty_out !== 1'b1) begin $display("FAIL rst_empty: got %b exp 1", empty_out); n_fail++; end
        n_cmp++; if (full_out !== 1'b0) begin $display("FAIL rst_full: got %b exp 0", full_out); n_fail++; end
        n_cmp++; if (err_out !== 2'b00) begin $display("FAIL rst_err: got %b exp 00", err_out); n_fail++; end
        rst = 1'b0;
        tick(2);
        n_cmp++; if (status_out !== 1'b1) begin $display("FAIL rst_status_rise: got %b exp 1 within 2 clocks", status_out); n_fail++; end
    endtask

    task automatic test_basic();
        load_word(8'h99);
        n_cmp++; if (status_out !== 1'b0) begin $display("FAIL basic_hold_status: got %b exp 0", status_out); n_fail++; end
        n_cmp++; if (count_out !== 4'd0) begin $display("FAIL basic_count0: got %0d exp 0", count_out); n_fail++; end
        do_enq();
        sb.push_back(8'h99);
        n_cmp++; if (status_out !== 1'b1) begin $display("FAIL basic_load_status: got %b exp 1", status_out); n_fail++; end
        n_cmp++; if (count_out !== 4'd1) begin $display("FAIL basic_count1: got %0d exp 1", count_out); n_fail++; end
        do_deq();
        exp_w = sb.pop_front();
        n_cmp++; if (data_out !== exp_w) begin $display("FAIL basic_data: got %h exp %h", data_out, exp_w); n_fail++; end
        n_cmp++; if (count_out !== 4'd0) begin $display("FAIL basic_count_end: got %0d exp 0", count_out); n_fail++; end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 8; i++) begin
            load_word(8'(i));
            do_enq();
            sb.push_back(8'(i));
        end
        n_cmp++; if (full_out !== 1'b1) begin $display("FAIL fill_full: got %b exp 1", full_out); n_fail++; end
        n_cmp++; if (count_out !== 4'd8) begin $display("FAIL fill_count: got %0d exp 8", count_out); n_fail++; end
        load_word(8'h09);
        do_enq();
        n_cmp++; if (err_out !== 2'b01) begin $display("FAIL ovf_err: got %b exp 01", err_out); n_fail++; end
        n_cmp++; if (status_out !== 1'b0) begin $display("FAIL ovf_hold: got %b exp 0", status_out); n_fail++; end
        n_cmp++; if (count_out !== 4'd8) begin $display("FAIL ovf_count: got %0d exp 8", count_out); n_fail++; end
        for (int i = 0; i < 8; i++) begin
            do_deq();
            exp_w = sb.pop_front();
            n_cmp++; if (data_out !== exp_w) begin $display("FAIL drain_data[%0d]: got %h exp %h", i, data_out, exp_w); n_fail++; end
        end
        n_cmp++; if (empty_out !== 1'b1) begin $display("FAIL drain_empty: got %b exp 1", empty_out); n_fail++; end
    endtask

    task automatic test_underflow();
        do_deq();
        n_cmp++; if (data_out !== 8'h08) begin $display("FAIL unf_data_hold: got %h exp 08", data_out); n_fail++; end
        n_cmp++; if (err_out !== 2'b11) begin $display("FAIL unf_err: got %b exp 11", err_out); n_fail++; end
        // The word refused on overflow is still held and pushes now.
        do_enq();
        sb.push_back(8'h09);
        n_cmp++; if (count_out !== 4'd1) begin $display("FAIL held_push_count: got %0d exp 1", count_out); n_fail++; end
        do_deq();
        exp_w = sb.pop_front();
        n_cmp++; if (data_out !== exp_w) begin $display("FAIL held_push_data: got %h exp %h", data_out, exp_w); n_fail++; end
    endtask

    task automatic test_wrap();
        logic [7:0] w;
        for (int i = 0; i < 20; i++) begin
            w = 8'((i * 37 + 5) & 8'hFF);
            load_word(w);
            do_enq();
            sb.push_back(w);
            do_deq();
            exp_w = sb.pop_front();
            n_cmp++; if (data_out !== exp_w) begin $display("FAIL wrap_data[%0d]: got %h exp %h", i, data_out, exp_w); n_fail++; end
        end
        n_cmp++; if (count_out !== 4'd0) begin $display("FAIL wrap_count: got %0d exp 0", count_out); n_fail++; end
    endtask

    task automatic test_simultaneous_full();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            load_word(8'(8'h10 + i));
            do_enq();
            sb.push_back(8'(8'h10 + i));
        end
        load_word(8'hA5);
        enqueue_in = 1'b1;
        dequeue_in = 1'b1;
        tick(10);
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        tick(10);
        exp_w = sb.pop_front();
        sb.push_back(8'hA5);
        n_cmp++; if (data_out !== exp_w) begin $display("FAIL simul_data: got %h exp %h", data_out, exp_w); n_fail++; end
        n_cmp++; if (count_out !== 4'd8) begin $display("FAIL simul_count: got %0d exp 8", count_out); n_fail++; end
        n_cmp++; if (err_out !== 2'b00) begin $display("FAIL simul_err: got %b exp 00", err_out); n_fail++; end
        n_cmp++; if (status_out !== 1'b1) begin $display("FAIL simul_status: got %b exp 1", status_out); n_fail++; end
        for (int i = 0; i < 8; i++) begin
            do_deq();
            exp_w = sb.pop_front();
            n_cmp++; if (data_out !== exp_w) begin $display("FAIL simul_drain[%0d]: got %h exp %h", i, data_out, exp_w); n_fail++; end
        end
    endtask

    task automatic test_mid_reset();
        load_word(8'h77);
        do_enq();
        for (int k = 0; k < 5; k++) begin
            strobe_bit(1'b1);
        end
        rst = 1'b1;
        tick(1);
        n_cmp++; if (count_out !== 4'd0) begin $display("FAIL midrst_count: got %0d exp 0", count_out); n_fail++; end
        n_cmp++; if (data_out !== 8'h00) begin $display("FAIL midrst_data: got %h exp 00", data_out); n_fail++; end
        n_cmp++; if (status_out !== 1'b0) begin $display("FAIL midrst_status: got %b exp 0", status_out); n_fail++; end
        n_cmp++; if (empty_out !== 1'b1) begin $display("FAIL midrst_empty: got %b exp 1", empty_out); n_fail++; end
        apply_reset();
        load_word(8'h3C);
        do_enq();
        sb.push_back(8'h3C);
        do_deq();
        exp_w = sb.pop_front();
        n_cmp++; if (data_out !== exp_w) begin $display("FAIL midrst_reload: got %h exp %h", data_out, exp_w); n_fail++; end
    endtask

`ifdef SERIAL_WORD_QUEUE_DEBOUNCE_EN
    task automatic test_glitch();
        data_in  = 1'b1;
        write_in = 1'b1;
        tick(2);
        write_in = 1'b0;
        tick(12);
        load_word(8'h5A);
        do_enq();
        sb.push_back(8'h5A);
        do_deq();
        exp_w = sb.pop_front();
        n_cmp++; if (data_out !== exp_w) begin $display("FAIL glitch_data: got %h exp %h", data_out, exp_w); n_fail++; end
    endtask
`endif

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        data_in    = 1'b0;
        write_in   = 1'b0;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;

        test_reset();
        test_basic();
        test_fill_overflow();
        test_underflow();
        test_wrap();
        test_simultaneous_full();
        test_mid_reset();
`ifdef SERIAL_WORD_QUEUE_DEBOUNCE_EN
        test_glitch();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute watchdog so the run always terminates.
    initial begin
        #60_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/serial_word_queue.md
Name: serial_word_queue

Overview:
Parametrised successor to the 8-bit serial-load/queue datapath behind TOP.
- Assembles a DATA_W-bit word from single bits strobed in on write_in.
- On enqueue_in, pushes the word into a DEPTH-entry circular FIFO; on dequeue_in, pops the oldest entry to data_out.
- Control inputs are slow, button-like levels. They are synchronised and edge-detected internally. Adds occupancy, full/empty and sticky error reporting.

Parameters:
- DATA_W, 8, word width in bits (>=2).
- DEPTH, 8, FIFO entries (power of two, >=2).
- LSB_FIRST, 1, 1: the k-th strobed bit lands in bit k; 0: the k-th strobed bit lands in bit DATA_W-1-k.
- DEBOUNCE_CYC, 4, stable cycles required per control input when DEBOUNCE_EN is defined.

Ports:
- clock_1MHz  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  1  serial data bit, sampled on a write_in rising edge.
- write_in  in  1  bit strobe (level input; the rising edge acts).
- enqueue_in  in  1  push request (level input; the rising edge acts).
- dequeue_in  in  1  pop request (level input; the rising edge acts).
- status_out  out  1  1 = ready to accept serial bits (LOAD state).
- data_out  out  DATA_W  last dequeued word (registered).
- count_out  out  $clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH.
- full_out  out  1  count_out == DEPTH.
- empty_out  out  1  count_out == 0.
- err_out  out  2  sticky flags: [0] overflow (enqueue while full), [1] underflow (dequeue while empty).

Behaviour:
- Reset (async assert, sync release): state=IDLE, status_out=0, data_out=0, count_out=0, empty_out=1, full_out=0, err_out=0, shift register and bit counter cleared, synchroniser flops cleared. FIFO RAM contents are don't-care.
- Input conditioning:
  - write_in, enqueue_in, dequeue_in, data_in each pass through a 2-flop synchroniser.
  - Each control input has a rising-edge detector giving a one-cycle pulse.
  - Latency from input rise to pulse is 3 clocks. data_in is taken from its synchronised copy in the same cycle as the write pulse.
- FSM:
  - IDLE -> LOAD unconditionally on the first clock after reset release.
  - LOAD: status_out=1. Each write pulse stores data_in at the position set by LSB_FIRST and increments bit_cnt. When bit_cnt reaches DATA_W, go to HOLD and clear bit_cnt.
  - HOLD: status_out=0. Write pulses are ignored. An enqueue pulse with FIFO not full pushes the word and returns to LOAD; status_out rises the next cycle.
  - HOLD with enqueue while full: set err_out[0], stay in HOLD, keep the word.
- Enqueue pulse in LOAD: ignored, no push, no error.
- Dequeue pulse in any state: if not empty, data_out <= mem[rd_ptr], rd_ptr++, count--. data_out updates 1 clock after the pulse. If empty: data_out holds and err_out[1] is set.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH. count_out is tracked separately.
- Enqueue and dequeue pulses in the same cycle:
  - Both legal: count is unchanged, pointers both advance.
  - Full: the pop and push both succeed with no overflow.
  - Empty: the push succeeds, the pop is ignored and underflow is flagged; no bypass.
- err_out bits clear only on rst.
- rst asserted mid-word or mid-pop: immediate return to the reset values; any partial word is discarded.

Optional Feature:
- Macro SERIAL_WORD_QUEUE_DEBOUNCE_EN.
- Defined: each synchronised control input must hold a new level for DEBOUNCE_CYC consecutive clocks before its filtered level changes. The edge detector acts on the filtered level, so latency becomes 3+DEBOUNCE_CYC clocks and glitches shorter than DEBOUNCE_CYC are rejected.
- Undefined: no filter; the edge detector acts directly on the synchronised level.

Decomposition:
- Package serial_word_queue_pkg holds:
  - the state enum typedef (IDLE, LOAD, HOLD);
  - err_out bit index constants (ERR_OVF=0, ERR_UNF=1);
  - a width helper for count_out.
- One sub-module, sync_edge_det: 2-flop synchroniser, optional debounce filter, rising-edge pulse output. It is instantiated three times, once per control input. data_in uses a plain synchroniser.

Test Plan:
- Reset release -> status_out rises within 2 clocks; count_out=0, empty_out=1, data_out=0, err_out=0.
- Strobe 8'b10011001 LSB-first (bit0 first), write_in held 10 clocks per bit, then enqueue, then dequeue -> status_out falls after the 8th bit and rises after enqueue; count_out goes 0->1->0; data_out=8'h99.
- Push words 0x01..0x08 (DEPTH=8) -> full_out=1. Ninth enqueue -> err_out=2'b01, state stays HOLD. Dequeue 8 times -> data_out follows 0x01..0x08 in order, empty_out=1.
- Dequeue on empty -> err_out[1]=1, data_out unchanged. Push and pop 20 words through -> no data corruption across pointer wrap.
- Full FIFO plus simultaneous enqueue/dequeue pulses -> count_out stays 8, oldest word popped, new word at the tail, no overflow flag.
- rst asserted after 5 of 8 bits -> outputs return to reset values. Next full word loads from bit 0. With the macro defined, a 2-clock glitch on write_in produces no bit stored.
